// File: rtl/counter_run_ctrl.sv
// rtl/counter_run_ctrl.sv - start-button conditioning and idle/load/armed/run/paused/done sequencing for the up/down counter
// Optional feature: define COUNTER_RUN_CTRL_AUTO_RELOAD_EN to reload and keep running at the count limit instead of stopping in DONE.
module counter_run_ctrl #(
  parameter int unsigned TICK_DIV        = 1000000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startbutton,
  input  logic [1:0] select,
  input  logic       at_limit,
  output logic       cnt_load,
  output logic [1:0] cnt_mode,
  output logic       cnt_up,
  output logic       cnt_step,
  output logic       running,
  output logic       done,
  output logic [2:0] state_dbg
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV);
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ARMED  = 3'd2,
    S_RUN    = 3'd3,
    S_PAUSED = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t            state;
  logic              sync1;
  logic              sync2;
  logic              db_level;
  logic [DB_W-1:0]   db_cnt;
  logic              press;
  logic [DIV_W-1:0]  div;

  assign state_dbg = state;

  // Synchronize the raw button, accept a level only after it has been stable long enough, pulse on accepted rises
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      db_level <= 1'b0;
      db_cnt   <= '0;
      press    <= 1'b0;
    end else begin
      sync1 <= startbutton;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != db_level) begin
        if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_level <= sync2;
          db_cnt   <= '0;
          press    <= sync2;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Sequencer with registered outputs; the divider only advances in RUN and holds while paused
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt_load <= 1'b0;
      cnt_mode <= 2'b00;
      cnt_up   <= 1'b0;
      cnt_step <= 1'b0;
      running  <= 1'b0;
      done     <= 1'b0;
      div      <= '0;
    end else begin
      cnt_load <= 1'b0;
      cnt_step <= 1'b0;
`ifdef COUNTER_RUN_CTRL_AUTO_RELOAD_EN
      done     <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          state    <= S_LOAD;
          cnt_load <= 1'b1;
          cnt_mode <= select;
          cnt_up   <= ~select[1];
        end
        S_LOAD: begin
          state <= S_ARMED;
        end
        S_ARMED: begin
          if (press) begin
            state   <= S_RUN;
            running <= 1'b1;
            div     <= '0;
          end else if (select != cnt_mode) begin
            state    <= S_LOAD;
            cnt_load <= 1'b1;
            cnt_mode <= select;
            cnt_up   <= ~select[1];
          end
        end
        S_RUN: begin
          if (press) begin
            state   <= S_PAUSED;
            running <= 1'b0;
          end else if (div == DIV_W'(TICK_DIV - 1)) begin
            div <= '0;
            if (!at_limit) begin
              cnt_step <= 1'b1;
            end else begin
`ifdef COUNTER_RUN_CTRL_AUTO_RELOAD_EN
              cnt_load <= 1'b1;
              done     <= 1'b1;
`else
              state    <= S_DONE;
              running  <= 1'b0;
              done     <= 1'b1;
`endif
            end
          end else begin
            div <= div + DIV_W'(1);
          end
        end
        S_PAUSED: begin
          if (press) begin
            state   <= S_RUN;
            running <= 1'b1;
          end
        end
        S_DONE: begin
          if (press) begin
            state    <= S_LOAD;
            done     <= 1'b0;
            cnt_load <= 1'b1;
            cnt_mode <= select;
            cnt_up   <= ~select[1];
          end
        end
        default: begin
          state   <= S_IDLE;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_run_ctrl.sv
// tb/tb_counter_run_ctrl.sv - directed self-checking bench for counter_run_ctrl (TICK_DIV=4, DEBOUNCE_CYCLES=3)
module tb_counter_run_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       startbutton;
  logic [1:0] select;
  logic       at_limit;
  logic       cnt_load;
  logic [1:0] cnt_mode;
  logic       cnt_up;
  logic       cnt_step;
  logic       running;
  logic       done;
  logic [2:0] state_dbg;
  logic [9:0] outs;

  int vectors     = 0;
  int miscompares = 0;

  counter_run_ctrl #(
    .TICK_DIV        (4),
    .DEBOUNCE_CYCLES (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .startbutton (startbutton),
    .select      (select),
    .at_limit    (at_limit),
    .cnt_load    (cnt_load),
    .cnt_mode    (cnt_mode),
    .cnt_up      (cnt_up),
    .cnt_step    (cnt_step),
    .running     (running),
    .done        (done),
    .state_dbg   (state_dbg)
  );

  // {cnt_load, cnt_mode, cnt_up, cnt_step, running, done, state_dbg}
  assign outs = {cnt_load, cnt_mode, cnt_up, cnt_step, running, done, state_dbg};

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; startbutton = 1'b0; select = 2'b00; at_limit = 1'b0;
    cyc(3);
    vectors++;
    if (outs !== 10'b0) begin miscompares++; $display("FAIL reset_state: got %b want %b", outs, 10'b0); end
    reset = 1'b0;
    cyc(1);
    vectors++;
    if (outs !== 10'b1_00_1_0_0_0_001) begin miscompares++; $display("FAIL reset_load: got %b want %b", outs, 10'b1_00_1_0_0_0_001); end
    cyc(1);
    vectors++;
    if (outs !== 10'b0_00_1_0_0_0_010) begin miscompares++; $display("FAIL reset_armed: got %b want %b", outs, 10'b0_00_1_0_0_0_010); end
  endtask

  task automatic test_bounce_run;
    logic [2:0] exp_state;
    logic [2:0] got;
    logic       exp_step;
    int         steps;
    startbutton = 1'b1; cyc(1);
    startbutton = 1'b0; cyc(1);
    startbutton = 1'b1;
    for (int j = 3; j <= 8; j++) begin
      cyc(1);
      exp_state = (j == 8) ? 3'd3 : 3'd2;
      vectors++;
      if (state_dbg !== exp_state) begin miscompares++; $display("FAIL bounce_state j=%0d: got %0d want %0d", j, state_dbg, exp_state); end
    end
    steps = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc(1);
      exp_step = (k % 4 == 0);
      if (cnt_step === 1'b1) steps++;
      got = {running, cnt_step, cnt_load};
      vectors++;
      if (got !== {1'b1, exp_step, 1'b0}) begin miscompares++; $display("FAIL run_step k=%0d: got %b want %b", k, got, {1'b1, exp_step, 1'b0}); end
    end
    vectors++;
    if (steps != 10) begin miscompares++; $display("FAIL run_step_count: got %0d want 10", steps); end
  endtask

  task automatic test_pause;
    logic       found;
    logic [3:0] got;
    logic [3:0] exp;
    logic [6:0] hold;
    startbutton = 1'b0;
    cyc(8);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      cyc(1);
      if (cnt_step === 1'b1) found = 1'b1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL pause_sync: got no step want a step within 8 cycles"); end
    cyc(1);
    startbutton = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      cyc(1);
      got = {state_dbg, cnt_step};
      exp = {((j == 6) ? 3'd4 : 3'd3), (j == 3)};
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL pause_enter j=%0d: got %b want %b", j, got, exp); end
    end
    startbutton = 1'b0;
    select = 2'b01;
    for (int j = 1; j <= 8; j++) begin
      cyc(1);
      hold = {state_dbg, running, cnt_step, cnt_load, cnt_mode[1]};
      vectors++;
      if (hold !== 7'b100_0_0_0_0 || cnt_mode !== 2'b00) begin
        miscompares++; $display("FAIL pause_hold j=%0d: got %b/%b want 1000000/00", j, hold, cnt_mode);
      end
    end
    startbutton = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      cyc(1);
      got = {state_dbg, cnt_step};
      exp = {((j < 6) ? 3'd4 : 3'd3), (j == 8 || j == 12)};
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL pause_resume j=%0d: got %b want %b", j, got, exp); end
    end
    startbutton = 1'b0;
    cyc(8);
  endtask

  task automatic test_done;
    logic [3:0] got;
    logic [3:0] exp;
    int         steps;
    reset = 1'b1; select = 2'b10; at_limit = 1'b0; startbutton = 1'b0;
    cyc(2);
    vectors++;
    if (outs !== 10'b0) begin miscompares++; $display("FAIL done_reset: got %b want %b", outs, 10'b0); end
    reset = 1'b0;
    cyc(1);
    vectors++;
    if (outs !== 10'b1_10_0_0_0_0_001) begin miscompares++; $display("FAIL done_load_down: got %b want %b", outs, 10'b1_10_0_0_0_0_001); end
    cyc(1);
    vectors++;
    if (outs !== 10'b0_10_0_0_0_0_010) begin miscompares++; $display("FAIL done_armed: got %b want %b", outs, 10'b0_10_0_0_0_0_010); end
    startbutton = 1'b1;
    steps = 0;
    for (int j = 1; j <= 18; j++) begin
      cyc(1);
      if (j == 8) startbutton = 1'b0;
      if (cnt_step === 1'b1) steps++;
      got = {state_dbg, cnt_step};
      exp = {((j < 6) ? 3'd2 : ((j < 18) ? 3'd3 : 3'd5)), (j == 10 || j == 14)};
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL done_run j=%0d: got %b want %b", j, got, exp); end
      if (j == 14) at_limit = 1'b1;
    end
    vectors++;
    if (steps != 2) begin miscompares++; $display("FAIL done_step_count: got %0d want 2", steps); end
    vectors++;
    if (outs !== 10'b0_10_0_0_0_1_101) begin miscompares++; $display("FAIL done_state: got %b want %b", outs, 10'b0_10_0_0_0_1_101); end
    at_limit = 1'b0;
    cyc(4);
    vectors++;
    if (outs !== 10'b0_10_0_0_0_1_101) begin miscompares++; $display("FAIL done_hold: got %b want %b", outs, 10'b0_10_0_0_0_1_101); end
    startbutton = 1'b1;
    cyc(6);
    vectors++;
    if (outs !== 10'b1_10_0_0_0_0_001) begin miscompares++; $display("FAIL done_reload: got %b want %b", outs, 10'b1_10_0_0_0_0_001); end
    cyc(1);
    vectors++;
    if (outs !== 10'b0_10_0_0_0_0_010) begin miscompares++; $display("FAIL done_rearmed: got %b want %b", outs, 10'b0_10_0_0_0_0_010); end
    startbutton = 1'b0;
    cyc(8);
  endtask

  task automatic test_select_change;
    reset = 1'b1; select = 2'b01; at_limit = 1'b0; startbutton = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    vectors++;
    if (outs !== 10'b1_01_1_0_0_0_001) begin miscompares++; $display("FAIL sel_load01: got %b want %b", outs, 10'b1_01_1_0_0_0_001); end
    cyc(1);
    vectors++;
    if (outs !== 10'b0_01_1_0_0_0_010) begin miscompares++; $display("FAIL sel_armed01: got %b want %b", outs, 10'b0_01_1_0_0_0_010); end
    select = 2'b11;
    cyc(1);
    vectors++;
    if (outs !== 10'b1_11_0_0_0_0_001) begin miscompares++; $display("FAIL sel_load11: got %b want %b", outs, 10'b1_11_0_0_0_0_001); end
    cyc(1);
    vectors++;
    if (outs !== 10'b0_11_0_0_0_0_010) begin miscompares++; $display("FAIL sel_armed11: got %b want %b", outs, 10'b0_11_0_0_0_0_010); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] got;
    startbutton = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      cyc(1);
      if (j == 6) begin
        vectors++;
        if (outs !== 10'b0_11_0_0_1_0_011) begin miscompares++; $display("FAIL priority_run: got %b want %b", outs, 10'b0_11_0_0_1_0_011); end
        startbutton = 1'b0;
      end
      if (j >= 7 && j <= 9) begin
        got = {state_dbg, cnt_step};
        vectors++;
        if (got !== 4'b011_0) begin miscompares++; $display("FAIL priority_nostep j=%0d: got %b want 0110", j, got); end
      end
      if (j == 10) begin
        vectors++;
        if (outs !== 10'b0) begin miscompares++; $display("FAIL reset_mid_run: got %b want %b", outs, 10'b0); end
      end
      if (j == 5) select = 2'b00;
      if (j == 9) reset = 1'b1;
    end
  endtask

`ifdef COUNTER_RUN_CTRL_AUTO_RELOAD_EN
  task automatic test_auto_reload;
    logic [3:0] got;
    logic [3:0] exp;
    reset = 1'b1; select = 2'b00; at_limit = 1'b0; startbutton = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(2);
    startbutton = 1'b1;
    for (int j = 1; j <= 18; j++) begin
      cyc(1);
      if (j == 8) startbutton = 1'b0;
      got = {state_dbg, cnt_step};
      exp = {((j < 6) ? 3'd2 : 3'd3), (j == 10 || j == 18)};
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL auto_run j=%0d: got %b want %b", j, got, exp); end
      if (j == 14) begin
        vectors++;
        if (outs !== 10'b1_00_1_0_1_1_011) begin miscompares++; $display("FAIL auto_reload: got %b want %b", outs, 10'b1_00_1_0_1_1_011); end
        at_limit = 1'b0;
      end
      if (j == 15) begin
        vectors++;
        if (outs !== 10'b0_00_1_0_1_0_011) begin miscompares++; $display("FAIL auto_after: got %b want %b", outs, 10'b0_00_1_0_1_0_011); end
      end
      if (j == 10) at_limit = 1'b1;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_bounce_run();
    test_pause();
`ifndef COUNTER_RUN_CTRL_AUTO_RELOAD_EN
    test_done();
`endif
    test_select_change();
    test_back_to_back();
`ifdef COUNTER_RUN_CTRL_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
